test_mul_pipe_hs: RTL
=====================

Name: test_mul_pipe_hs

Overview:
- Parametrised pipelined integer multiplier with a valid/ready handshake. Computes din0*din1, unsigned or signed per transaction, with a configurable pipeline depth.
- Next generation of the combinational 32x32->64 multiplier used in the fiat_p448 carry_mul datapath. Lets HLS-scheduled limb products be registered and stalled under downstream backpressure.
- Operand and product widths are generic. Default is 32x32->64.

Parameters:
- ID, 1, instance identifier; no functional effect.
- NUM_STAGE, 3, pipeline latency in cycles; legal range 1..4.
- din0_WIDTH, 32, width of operand 0.
- din1_WIDTH, 32, width of operand 1.
- dout_WIDTH, 64, product width; the result is the low dout_WIDTH bits of the full product.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid this cycle.
- in_ready  out  1  block accepts operands this cycle.
- in_signed  in  1  1 = two's-complement operands; 0 = unsigned.
- din0  in  din0_WIDTH  operand 0.
- din1  in  din1_WIDTH  operand 1.
- out_valid  out  1  dout holds a valid product.
- out_ready  in  1  consumer accepts dout this cycle.
- dout  out  dout_WIDTH  product.

Behaviour:
- Reset (ap_rst_n=0, asynchronous):
  - All stage valid bits clear to 0, so out_valid=0.
  - dout=0; all data registers clear to 0.
  - in_ready=1 while in reset and after release.
  - Reset asserted mid-operation discards all in-flight products. No output appears after reset deassertion until new operands are accepted.
- Pipeline enable: ce = !(out_valid && !out_ready). When ce=0, every stage register and valid bit holds. in_ready = ce (combinational).
- Accept: a transfer occurs when in_valid && in_ready. Operands and in_signed are captured into stage 1 with valid=1. If in_valid=0 while ce=1, a bubble (valid=0) enters.
- Latency: a product accepted at edge k presents out_valid=1 after edge k+NUM_STAGE-1, provided there are no stalls. Each stall cycle adds exactly one cycle.
- Throughput: one product per cycle while out_ready=1. Bubbles are not collapsed.
- Order: outputs leave in acceptance order. Every accepted transaction produces exactly one output handshake.
- Arithmetic:
  - in_signed=0: operands are zero-extended.
  - in_signed=1: operands are sign-extended.
  - The full product is din0_WIDTH+din1_WIDTH bits wide. dout takes its low dout_WIDTH bits; if dout_WIDTH exceeds the full width, the result is extended per in_signed.
- Partitioning for NUM_STAGE>=3:
  - Stage 1 registers the operands.
  - The middle stages register partial products of operand halves, split at ceil(width/2).
  - The final stage registers the summed product.
  - For NUM_STAGE=4 there is an additional register after partial-product summation. For NUM_STAGE=1 there is a single product register; for 2, operand and product registers.
- Stall: out_valid and dout stay stable while out_ready=0. in_ready=0 exactly when out_valid=1 and out_ready=0.
- Simultaneous accept and deliver with ce=1: both occur in the same cycle.
- Simulation-only elaboration check: error if NUM_STAGE is outside 1..4 or any width is <1.

Optional Feature:
- Macro: TEST_MUL_PIPE_ACC_EN.
- Defined:
  - Adds input port din2 [dout_WIDTH-1:0], captured with the operands.
  - dout = (din0*din1 + din2) mod 2^dout_WIDTH. The addend is extended per in_signed and added in the final stage; latency is unchanged.
  - Used for fiat carry-chain multiply-add.
- Undefined: port din2 is absent and dout = din0*din1 only.

Test Plan:
- Reset then NUM_STAGE=3, unsigned 0xFFFFFFFF*0xFFFFFFFF, out_ready=1 -> out_valid exactly 3 edges after accept, dout=0xFFFFFFFE00000001, in_ready=1 throughout.
- Signed: din0=0xFFFFFFFF (-1), din1=0x00000002 -> dout=0xFFFFFFFFFFFFFFFE. The same operands with in_signed=0 -> 0x00000001FFFFFFFE.
- Back-to-back stream of 8 products (i*0x10001, i=1..8) with out_ready low on cycles 4-6:
  - Outputs appear in order, with no loss or duplication.
  - dout is held stable during the stall.
  - in_ready=0 only while out_valid=1 and out_ready=0.
- Assert ap_rst_n=0 with 3 products in flight -> out_valid=0 and dout=0 immediately. After release, no output until a new accept.
- Parameter sweep: NUM_STAGE=1..4 with 14x12->26, din0=0x3FFF, din1=0xFFF -> dout=0x3FFB001 at latency NUM_STAGE.
- With TEST_MUL_PIPE_ACC_EN: din0=3, din1=5, din2=0xFFFFFFFFFFFFFFFF, unsigned -> dout=0x000000000000000E (wraps).

Source files
------------

// File: rtl/test_mul_pipe_hs_if.sv
// test_mul_pipe_hs_if: operand/product handshake bundle for test_mul_pipe_hs.
// Carries din2 only when TEST_MUL_PIPE_ACC_EN is defined.
interface test_mul_pipe_hs_if #(
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_signed;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
`ifdef TEST_MUL_PIPE_ACC_EN
    logic [dout_WIDTH-1:0] din2;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [dout_WIDTH-1:0] dout;

    modport master (
        output in_valid, in_signed, din0, din1,
`ifdef TEST_MUL_PIPE_ACC_EN
        output din2,
`endif
        output out_ready,
        input  in_ready, out_valid, dout
    );

    modport slave (
        input  in_valid, in_signed, din0, din1,
`ifdef TEST_MUL_PIPE_ACC_EN
        input  din2,
`endif
        input  out_ready,
        output in_ready, out_valid, dout
    );
endinterface

// File: rtl/test_mul_pipe_hs.sv
// test_mul_pipe_hs: pipelined signed/unsigned multiplier with valid/ready handshake.
// Define TEST_MUL_PIPE_ACC_EN to add a din2 addend (multiply-add) in the final stage.
module test_mul_pipe_hs #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 64
) (
    input logic ap_clk,
    input logic ap_rst_n,
    test_mul_pipe_hs_if.slave bus
);
    localparam int P  = (din0_WIDTH + din1_WIDTH > dout_WIDTH) ? din0_WIDTH + din1_WIDTH : dout_WIDTH;
    localparam int HA = (din0_WIDTH + 1) / 2;
    localparam int HB = (din1_WIDTH + 1) / 2;

    if (NUM_STAGE < 1 || NUM_STAGE > 4 || din0_WIDTH < 1 || din1_WIDTH < 1 || dout_WIDTH < 1) begin : g_bad_cfg
        $error("test_mul_pipe_hs ID=%0d: NUM_STAGE must be 1..4 and widths >= 1", ID);
    end

    logic                  ce;
    logic [NUM_STAGE-1:0]  v;
    logic [dout_WIDTH-1:0] r;
    logic [dout_WIDTH-1:0] addend;

    // Operands are extended to the working width P so the low bits of the product are exact for both signednesses
    function automatic logic [P-1:0] ext0(input logic [din0_WIDTH-1:0] a, input logic s);
        return {{(P - din0_WIDTH){s & a[din0_WIDTH-1]}}, a};
    endfunction

    function automatic logic [P-1:0] ext1(input logic [din1_WIDTH-1:0] b, input logic s);
        return {{(P - din1_WIDTH){s & b[din1_WIDTH-1]}}, b};
    endfunction

    assign ce            = !(v[NUM_STAGE-1] && !bus.out_ready);
    assign bus.in_ready  = ce;
    assign bus.out_valid = v[NUM_STAGE-1];
    assign bus.dout      = r;
`ifdef TEST_MUL_PIPE_ACC_EN
    assign addend = bus.din2;
`else
    assign addend = '0;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) v <= '0;
        else if (ce)   v <= (v << 1) | NUM_STAGE'(bus.in_valid);

    if (NUM_STAGE == 1) begin : g_s1
        always_ff @(posedge ap_clk or negedge ap_rst_n)
            if (!ap_rst_n) r <= '0;
            else if (ce)   r <= dout_WIDTH'(ext0(bus.din0, bus.in_signed) * ext1(bus.din1, bus.in_signed)) + addend;
    end else begin : g_sn
        logic [din0_WIDTH-1:0] a1;
        logic [din1_WIDTH-1:0] b1;
        logic                  s1;
        logic [dout_WIDTH-1:0] c1;

        always_ff @(posedge ap_clk or negedge ap_rst_n)
            if (!ap_rst_n) begin
                a1 <= '0;
                b1 <= '0;
                s1 <= 1'b0;
                c1 <= '0;
            end else if (ce) begin
                a1 <= bus.din0;
                b1 <= bus.din1;
                s1 <= bus.in_signed;
                c1 <= addend;
            end

        if (NUM_STAGE == 2) begin : g_s2
            always_ff @(posedge ap_clk or negedge ap_rst_n)
                if (!ap_rst_n) r <= '0;
                else if (ce)   r <= dout_WIDTH'(ext0(a1, s1) * ext1(b1, s1)) + c1;
        end else begin : g_s34
            logic [P-1:0]          ax, bx, ps;
            logic [P-1:0]          pp [4];
            logic [dout_WIDTH-1:0] c2;

            assign ax = ext0(a1, s1);
            assign bx = ext1(b1, s1);
            assign ps = pp[0] + pp[1] + pp[2] + pp[3];

            // Low halves are unsigned; high parts carry the extension, so modular sums stay exact
            always_ff @(posedge ap_clk or negedge ap_rst_n)
                if (!ap_rst_n) begin
                    pp <= '{default: '0};
                    c2 <= '0;
                end else if (ce) begin
                    pp[0] <= P'(ax[HA-1:0]) * P'(bx[HB-1:0]);
                    pp[1] <= (P'(ax[HA-1:0]) * (bx >> HB)) << HB;
                    pp[2] <= ((ax >> HA) * P'(bx[HB-1:0])) << HA;
                    pp[3] <= ((ax >> HA) * (bx >> HB)) << (HA + HB);
                    c2    <= c1;
                end

            if (NUM_STAGE == 3) begin : g_s3
                always_ff @(posedge ap_clk or negedge ap_rst_n)
                    if (!ap_rst_n) r <= '0;
                    else if (ce)   r <= dout_WIDTH'(ps) + c2;
            end else begin : g_s4
                logic [P-1:0]          s3;
                logic [dout_WIDTH-1:0] c3;

                always_ff @(posedge ap_clk or negedge ap_rst_n)
                    if (!ap_rst_n) begin
                        s3 <= '0;
                        c3 <= '0;
                        r  <= '0;
                    end else if (ce) begin
                        s3 <= ps;
                        c3 <= c2;
                        r  <= dout_WIDTH'(s3) + c3;
                    end
            end
        end
    end
endmodule
